// File: rtl/cla_pkg.sv
// Shared constants, types and the 4-bit carry-lookahead function for the pipelined CLA adder.
package cla_pkg;

    localparam int unsigned GRP_W     = 4;
    localparam int unsigned MAX_WIDTH = 64;

    typedef struct packed {
        logic g;
        logic p;
    } grp_gp_t;

    typedef struct packed {
        logic [3:0] carries;
        grp_gp_t    gp;
    } cla4_t;

    // carries[i] is the carry into bit i of the group; carries[0] is ci.
    function automatic cla4_t cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        cla4_t r;
        r.carries[0] = ci;
        r.carries[1] = g[0] | (p[0] & ci);
        r.carries[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        r.carries[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        r.gp.g       = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.gp.p       = &p;
        return r;
    endfunction

endpackage

// File: rtl/cla_grp4.sv
// Combinational 4-bit carry-lookahead group: intra-group carries plus group generate/propagate.
module cla_grp4
    import cla_pkg::*;
(
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       ci,
    output logic [3:0] carries,
    output logic       G,
    output logic       P
);

    cla4_t res;

    always_comb begin
        res     = cla4(g, p, ci);
        carries = res.carries;
        G       = res.gp.g;
        P       = res.gp.p;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional signed-overflow output enabled by defining CLA_OVF_FLAG_EN.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             grp_g,
    output logic             grp_p
`ifdef CLA_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NGRP = WIDTH / GRP_W;

    if (((WIDTH % GRP_W) != 0) || (WIDTH > MAX_WIDTH) || (WIDTH < GRP_W)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 4..64");
    end

    // Second-level lookahead over the group G/P vector, seeded with c0.
    function automatic logic [NGRP:0] grp_chain(input logic [NGRP-1:0] gg,
                                                input logic [NGRP-1:0] gp,
                                                input logic            c0);
        logic [NGRP:0] k;
        k[0] = c0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            k[j+1] = gg[j] | (gp[j] & k[j]);
        end
        return k;
    endfunction

    logic             s1_valid, s2_valid;
    logic             s1_load, s2_load;
    logic [WIDTH-1:0] b_eff, bit_g, bit_p;
    logic [NGRP-1:0]  grp_g_c, grp_p_c;
    logic [WIDTH-1:0] s1_c_unused;

    logic [WIDTH-1:0] s1_g, s1_p;
    logic [NGRP-1:0]  s1_grp_g, s1_grp_p;
    logic             s1_ci;

    logic [NGRP:0]    k;
    logic [NGRP:0]    blk_k;
    logic [WIDTH-1:0] carry;
    logic [NGRP-1:0]  s2_g_unused, s2_p_unused;

    assign s2_load   = !s2_valid | out_ready;
    assign s1_load   = !s1_valid | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    assign b_eff = sub ? ~b : b;
    assign bit_g = a & b_eff;
    assign bit_p = a ^ b_eff;

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        cla_grp4 u_s1 (
            .g       (bit_g[j*GRP_W +: GRP_W]),
            .p       (bit_p[j*GRP_W +: GRP_W]),
            .ci      (1'b0),
            .carries (s1_c_unused[j*GRP_W +: GRP_W]),
            .G       (grp_g_c[j]),
            .P       (grp_p_c[j])
        );

        cla_grp4 u_s2 (
            .g       (s1_g[j*GRP_W +: GRP_W]),
            .p       (s1_p[j*GRP_W +: GRP_W]),
            .ci      (k[j]),
            .carries (carry[j*GRP_W +: GRP_W]),
            .G       (s2_g_unused[j]),
            .P       (s2_p_unused[j])
        );
    end

    // blk_k excludes ci so grp_g reflects the operands alone.
    assign k     = grp_chain(s1_grp_g, s1_grp_p, s1_ci);
    assign blk_k = grp_chain(s1_grp_g, s1_grp_p, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_grp_g <= '0;
            s1_grp_p <= '0;
            s1_ci    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_g     <= bit_g;
                s1_p     <= bit_p;
                s1_grp_g <= grp_g_c;
                s1_grp_p <= grp_p_c;
                s1_ci    <= sub | c_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            grp_g    <= 1'b0;
            grp_p    <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
            ovf      <= 1'b0;
`endif
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum   <= s1_p ^ carry;
                c_out <= k[NGRP];
                grp_g <= blk_k[NGRP];
                grp_p <= &s1_grp_p;
`ifdef CLA_OVF_FLAG_EN
                ovf   <= carry[WIDTH-1] ^ k[NGRP];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard testbench for cla_pipe_adder: directed vectors, streaming, stall and async reset.
module tb_cla_pipe_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b;
    logic             c_in, sub;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out, grp_g, grp_p;
`ifdef CLA_OVF_FLAG_EN
    logic             ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             grp_g;
        logic             grp_p;
        logic             ovf;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    logic [WIDTH-1:0] ra[8], rb[8];
    logic             rs[8], rc[8];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .grp_g     (grp_g),
        .grp_p     (grp_p)
`ifdef CLA_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    function automatic exp_t model(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                                   input logic ocin, input logic osub);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic             ci;
        logic [WIDTH:0]   full, noci;
        logic [WIDTH-1:0] low;
        bb      = osub ? ~ob : ob;
        ci      = osub ? 1'b1 : ocin;
        full    = {1'b0, oa} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
        noci    = {1'b0, oa} + {1'b0, bb};
        low     = {1'b0, oa[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, ci};
        e.sum   = full[WIDTH-1:0];
        e.c_out = full[WIDTH];
        e.grp_g = noci[WIDTH];
        e.grp_p = &(oa ^ bb);
        e.ovf   = low[WIDTH-1] ^ full[WIDTH];
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".sum"},   64'(sum),   64'(e.sum));
        check({tag, ".c_out"}, 64'(c_out), 64'(e.c_out));
        check({tag, ".grp_g"}, 64'(grp_g), 64'(e.grp_g));
        check({tag, ".grp_p"}, 64'(grp_p), 64'(e.grp_p));
`ifdef CLA_OVF_FLAG_EN
        check({tag, ".ovf"},   64'(ovf),   64'(e.ovf));
`endif
    endtask

    // One clock cycle, entered and left at a falling edge. exp_ov / exp_ir < 0 means unchecked.
    task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic vcin, input logic vsub,
                         input logic ordy, input int exp_ov, input int exp_ir, output logic took);
        exp_t e;
        in_valid  = v;
        a         = va;
        b         = vb;
        c_in      = vcin;
        sub       = vsub;
        out_ready = ordy;
        #1;
        if (exp_ov >= 0) check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
        if (exp_ir >= 0) check({tag, ".in_ready"},  64'(in_ready),  64'(exp_ir));
        if (out_valid) begin
            if (sb.size() == 0) begin
                check({tag, ".spurious_out_valid"}, 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                e = sb.pop_front();
                check_outputs({tag, ".result"}, e);
            end else begin
                check_outputs({tag, ".held"}, sb[0]);
            end
        end
        took = in_valid & in_ready;
        if (took) sb.push_back(model(va, vb, vcin, vsub));
        @(negedge clk);
    endtask

    task automatic single(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vcin, input logic vsub);
        logic took;
        cycle(tag, 1'b1, va, vb, vcin, vsub, 1'b1, -1, 1, took);
        cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 0, -1, took);
        cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1, -1, took);
        cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 0, -1, took);
    endtask

    initial begin
        logic        took;
        int unsigned idx;
        int          ov, ir;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #2;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check_outputs("reset", '{sum: '0, c_out: 1'b0, grp_g: 1'b0, grp_p: 1'b0, ovf: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        single("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
        single("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
        single("sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b1);
        single("add_cin",   16'h1234, 16'h0FFF, 1'b1, 1'b0);
        single("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0);
        single("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b1);
        single("no_ovf",    16'h0003, 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra[i] = WIDTH'($urandom);
            rb[i] = WIDTH'($urandom);
            rs[i] = 1'($urandom);
            rc[i] = 1'($urandom);
        end

        // Back-to-back stream, no back-pressure: results on cycles 2..9.
        for (int c = 0; c < 12; c++) begin
            ov = (c >= 2 && c <= 9) ? 1 : 0;
            ir = (c < 8) ? 1 : -1;
            if (c < 8) cycle("stream", 1'b1, ra[c], rb[c], rc[c], rs[c], 1'b1, ov, ir, took);
            else       cycle("stream", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, ir, took);
        end
        check("stream.drained", 64'(sb.size()), 64'd0);

        // Same stream with out_ready low on cycles 4..6; inputs held until accepted.
        idx = 0;
        for (int c = 0; c < 30 && (idx < 8 || sb.size() > 0); c++) begin
            ir = (c >= 4 && c <= 6) ? 0 : -1;
            if (idx < 8)
                cycle("stall", 1'b1, ra[idx], rb[idx], rc[idx], rs[idx], !(c >= 4 && c <= 6), -1, ir, took);
            else
                cycle("stall", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, -1, -1, took);
            if (took) idx++;
        end
        check("stall.accepted", 64'(idx), 64'd8);
        check("stall.drained",  64'(sb.size()), 64'd0);

        // Fill both stages, then reset asynchronously mid-cycle.
        cycle("rst_fill", 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, -1, 1, took);
        cycle("rst_fill", 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, -1, 1, took);
        in_valid = 1'b0;
        #1;
        check("rst_fill.out_valid", 64'(out_valid), 64'd1);
        check("rst_fill.in_ready",  64'(in_ready),  64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.out_valid", 64'(out_valid), 64'd0);
        check("async_rst.in_ready",  64'(in_ready),  64'd1);
        check_outputs("async_rst", '{sum: '0, c_out: 1'b0, grp_g: 1'b0, grp_p: 1'b0, ovf: 1'b0});
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle("post_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 0, 1, took);
        end
        single("post_rst_add", 16'hA5A5, 16'h5A5B, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
